// File: rtl/dmem_arbiter.sv
// Two-requester arbiter and strobe sequencer for the single data-memory port.
// Build option: define DMEM_ARB_RR_EN for round-robin ties; otherwise r0 has fixed priority.
module dmem_arbiter #(
  parameter int unsigned ACCESS_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r0_req,
  input  logic        r0_we,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r0_wdata,
  input  logic [3:0]  r0_sign_mask,
  output logic        r0_gnt,
  output logic        r0_done,
  output logic [31:0] r0_rdata,
  input  logic        r1_req,
  input  logic        r1_we,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r1_wdata,
  input  logic [3:0]  r1_sign_mask,
  output logic        r1_gnt,
  output logic        r1_done,
  output logic [31:0] r1_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_sign_mask,
  output logic        mem_memread,
  output logic        mem_memwrite,
  input  logic [31:0] mem_read_data
);

  localparam int unsigned CNT_W = (ACCESS_LAT > 1) ? $clog2(ACCESS_LAT) : 1;
  localparam int unsigned DW    = 32;
  localparam int unsigned MW    = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             owner_q, owner_d;
  logic             we_q, we_d;
  logic [DW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [MW-1:0]    mask_q, mask_d;
  logic             rd_q, rd_d;
  logic             wr_q, wr_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             done0_q, done0_d;
  logic             done1_q, done1_d;
  logic [DW-1:0]    rdata0_q, rdata0_d;
  logic [DW-1:0]    rdata1_q, rdata1_d;
  logic             win1_c;
  logic             sel_we_c;

`ifdef DMEM_ARB_RR_EN
  // 1 = r1 was granted last, so r0 takes the next tie
  logic             rr_last_q, rr_last_d;

  always_comb begin
    win1_c = r1_req & (~r0_req | ~rr_last_q);
  end
`else
  always_comb begin
    win1_c = r1_req & ~r0_req;
  end
`endif

  assign sel_we_c = win1_c ? r1_we : r0_we;

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    mask_d   = mask_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
`ifdef DMEM_ARB_RR_EN
    rr_last_d = rr_last_q;
`endif

    case (state_q)
      IDLE: begin
        if (r0_req || r1_req) begin
          state_d = ACCESS;
          cnt_d   = CNT_W'(0);
          owner_d = win1_c;
          we_d    = sel_we_c;
          addr_d  = win1_c ? r1_addr : r0_addr;
          wdata_d = win1_c ? r1_wdata : r0_wdata;
          mask_d  = win1_c ? r1_sign_mask : r0_sign_mask;
          rd_d    = ~sel_we_c;
          wr_d    = sel_we_c;
          gnt0_d  = ~win1_c;
          gnt1_d  = win1_c;
`ifdef DMEM_ARB_RR_EN
          rr_last_d = win1_c;
`endif
        end
      end
      ACCESS: begin
        if (cnt_q == CNT_W'(ACCESS_LAT - 1)) begin
          state_d = DONE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        // Strobes already low here; this cycle re-arms the memory phase
        state_d = IDLE;
        done0_d = ~owner_q;
        done1_d = owner_q;
        if (!we_q) begin
          if (owner_q) rdata1_d = mem_read_data;
          else         rdata0_d = mem_read_data;
        end
      end
      default: begin
        state_d = IDLE;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= CNT_W'(0);
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= DW'(0);
      wdata_q  <= DW'(0);
      mask_q   <= MW'(0);
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      rdata0_q <= DW'(0);
      rdata1_q <= DW'(0);
`ifdef DMEM_ARB_RR_EN
      rr_last_q <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      mask_q   <= mask_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
`ifdef DMEM_ARB_RR_EN
      rr_last_q <= rr_last_d;
`endif
    end
  end

  assign r0_gnt         = gnt0_q;
  assign r1_gnt         = gnt1_q;
  assign r0_done        = done0_q;
  assign r1_done        = done1_q;
  assign r0_rdata       = rdata0_q;
  assign r1_rdata       = rdata1_q;
  assign mem_addr       = addr_q;
  assign mem_write_data = wdata_q;
  assign mem_sign_mask  = mask_q;
  assign mem_memread    = rd_q;
  assign mem_memwrite   = wr_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter (default latency 2 plus a latency-3 instance).
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] mem_read_data;

  logic        r0_req, r0_we, r1_req, r1_we;
  logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic [3:0]  r0_sign_mask, r1_sign_mask;
  logic        r0_gnt, r0_done, r1_gnt, r1_done;
  logic [31:0] r0_rdata, r1_rdata;
  logic [31:0] mem_addr, mem_write_data;
  logic [3:0]  mem_sign_mask;
  logic        mem_memread, mem_memwrite;

  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic [3:0]  p0_sign_mask, p1_sign_mask;
  logic        p0_gnt, p0_done, p1_gnt, p1_done;
  logic [31:0] p0_rdata, p1_rdata;
  logic [31:0] p_addr, p_write_data;
  logic [3:0]  p_sign_mask;
  logic        p_memread, p_memwrite;

  int n_chk  = 0;
  int n_pass = 0;

  dmem_arbiter #(.ACCESS_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_sign_mask(r0_sign_mask), .r0_gnt(r0_gnt), .r0_done(r0_done), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_sign_mask(r1_sign_mask), .r1_gnt(r1_gnt), .r1_done(r1_done), .r1_rdata(r1_rdata),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_sign_mask(mem_sign_mask),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite), .mem_read_data(mem_read_data)
  );

  dmem_arbiter #(.ACCESS_LAT(3)) dut3 (
    .clk(clk), .rst(rst),
    .r0_req(p0_req), .r0_we(p0_we), .r0_addr(p0_addr), .r0_wdata(p0_wdata),
    .r0_sign_mask(p0_sign_mask), .r0_gnt(p0_gnt), .r0_done(p0_done), .r0_rdata(p0_rdata),
    .r1_req(p1_req), .r1_we(p1_we), .r1_addr(p1_addr), .r1_wdata(p1_wdata),
    .r1_sign_mask(p1_sign_mask), .r1_gnt(p1_gnt), .r1_done(p1_done), .r1_rdata(p1_rdata),
    .mem_addr(p_addr), .mem_write_data(p_write_data), .mem_sign_mask(p_sign_mask),
    .mem_memread(p_memread), .mem_memwrite(p_memwrite), .mem_read_data(mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Advance one clock; inputs and samples both land 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_g0, exp_g1;
    rst = 1'b1;
    mem_read_data = 32'h0;
    r0_req = 0; r0_we = 0; r0_addr = 0; r0_wdata = 0; r0_sign_mask = 0;
    r1_req = 0; r1_we = 0; r1_addr = 0; r1_wdata = 0; r1_sign_mask = 0;
    p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0; p0_sign_mask = 0;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0; p1_sign_mask = 0;
    tick(); tick();

    check("rst_r0_gnt",  32'(r0_gnt), 32'd0);
    check("rst_r0_done", 32'(r0_done), 32'd0);
    check("rst_r0_rdata", r0_rdata, 32'd0);
    check("rst_r1_rdata", r1_rdata, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_write_data, 32'd0);
    check("rst_mem_mask", 32'(mem_sign_mask), 32'd0);
    check("rst_memread", 32'(mem_memread), 32'd0);
    check("rst_memwrite", 32'(mem_memwrite), 32'd0);
    rst = 1'b0;

    // r0 read at 0x1004
    mem_read_data = 32'hDEADBEEF;
    r0_req = 1; r0_we = 0; r0_addr = 32'h1004; r0_sign_mask = 4'h2;
    tick();
    check("t1_gnt", 32'(r0_gnt), 32'd1);
    check("t1_r1_gnt", 32'(r1_gnt), 32'd0);
    check("t1_rd_c1", 32'(mem_memread), 32'd1);
    check("t1_wr_c1", 32'(mem_memwrite), 32'd0);
    check("t1_addr", mem_addr, 32'h1004);
    check("t1_mask", 32'(mem_sign_mask), 32'h2);
    r0_req = 0;
    tick();
    check("t1_gnt_pulse", 32'(r0_gnt), 32'd0);
    check("t1_rd_c2", 32'(mem_memread), 32'd1);
    tick();
    check("t1_rd_done_low", 32'(mem_memread), 32'd0);
    check("t1_done_early", 32'(r0_done), 32'd0);
    tick();
    check("t1_done", 32'(r0_done), 32'd1);
    check("t1_rdata", r0_rdata, 32'hDEADBEEF);
    check("t1_r1_done", 32'(r1_done), 32'd0);
    check("t1_r1_rdata", r1_rdata, 32'd0);
    mem_read_data = 32'h11111111;
    tick();
    check("t1_done_pulse", 32'(r0_done), 32'd0);
    check("t1_rdata_hold", r0_rdata, 32'hDEADBEEF);
    check("t1_addr_hold", mem_addr, 32'h1004);

    // r1 byte write of 0xA5 to the LED register
    mem_read_data = 32'h12345678;
    r1_req = 1; r1_we = 1; r1_addr = 32'h2000; r1_wdata = 32'hA5; r1_sign_mask = 4'h1;
    tick();
    check("t2_gnt", 32'(r1_gnt), 32'd1);
    check("t2_r0_gnt", 32'(r0_gnt), 32'd0);
    check("t2_wr_c1", 32'(mem_memwrite), 32'd1);
    check("t2_rd_c1", 32'(mem_memread), 32'd0);
    check("t2_addr", mem_addr, 32'h2000);
    check("t2_wdata", mem_write_data, 32'hA5);
    check("t2_mask", 32'(mem_sign_mask), 32'h1);
    r1_req = 0;
    tick();
    check("t2_wr_c2", 32'(mem_memwrite), 32'd1);
    tick();
    check("t2_wr_low", 32'(mem_memwrite), 32'd0);
    tick();
    check("t2_done", 32'(r1_done), 32'd1);
    check("t2_rdata_keep", r1_rdata, 32'd0);
    check("t2_r0_rdata_keep", r0_rdata, 32'hDEADBEEF);
    check("t2_wr_idle", 32'(mem_memwrite), 32'd0);

    // Both requesting continuously; previous grant was r1
    r0_we = 0; r1_we = 0;
    r0_req = 1; r1_req = 1;
    for (int k = 0; k < 16; k++) begin
      tick();
      exp_g0 = 1'b0;
      exp_g1 = 1'b0;
      if (k % 4 == 0) begin
`ifdef DMEM_ARB_RR_EN
        exp_g1 = ((k / 4) % 2) == 1;
        exp_g0 = !exp_g1;
`else
        exp_g0 = 1'b1;
`endif
      end
      check($sformatf("t3_r0_gnt_k%0d", k), 32'(r0_gnt), 32'(exp_g0));
      check($sformatf("t3_r1_gnt_k%0d", k), 32'(r1_gnt), 32'(exp_g1));
    end
    r0_req = 0; r1_req = 0;
    tick();
    check("t3_quiet", 32'(r0_gnt | r1_gnt), 32'd0);

    // Reset in the first ACCESS cycle aborts the access
    mem_read_data = 32'h0F0F0F0F;
    r0_req = 1; r0_we = 0; r0_addr = 32'h1000;
    tick();
    check("t4_gnt", 32'(r0_gnt), 32'd1);
    r0_req = 0; rst = 1;
    tick();
    check("t4_rd_abort", 32'(mem_memread), 32'd0);
    check("t4_gnt_abort", 32'(r0_gnt), 32'd0);
    check("t4_rdata_rst", r0_rdata, 32'd0);
    rst = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("t4_no_done_%0d", k), 32'(r0_done), 32'd0);
      check($sformatf("t4_no_rd_%0d", k), 32'(mem_memread), 32'd0);
    end
    mem_read_data = 32'hCAFEF00D;
    r0_req = 1; r0_addr = 32'h1008;
    tick();
    check("t4_re_gnt", 32'(r0_gnt), 32'd1);
    r0_req = 0;
    tick(); tick();
    check("t4_re_early", 32'(r0_done), 32'd0);
    tick();
    check("t4_re_done", 32'(r0_done), 32'd1);
    check("t4_re_rdata", r0_rdata, 32'hCAFEF00D);

    // r0 pulse during r1 ownership is dropped; held r0 wins right after r1 done
    mem_read_data = 32'h0BADF00D;
    r1_req = 1; r1_we = 0; r1_addr = 32'h3000;
    tick();
    check("t5_r1_gnt", 32'(r1_gnt), 32'd1);
    r1_req = 0; r0_req = 1; r0_addr = 32'h100C;
    tick();
    check("t5_pulse_gnt_a", 32'(r0_gnt), 32'd0);
    r0_req = 0;
    tick();
    check("t5_pulse_gnt_b", 32'(r0_gnt), 32'd0);
    r0_req = 1;
    tick();
    check("t5_r1_done", 32'(r1_done), 32'd1);
    check("t5_r1_rdata", r1_rdata, 32'h0BADF00D);
    check("t5_r0_gnt_wait", 32'(r0_gnt), 32'd0);
    mem_read_data = 32'h600DCAFE;
    tick();
    check("t5_r0_gnt", 32'(r0_gnt), 32'd1);
    check("t5_addr", mem_addr, 32'h100C);
    r0_req = 0;
    tick(); tick(); tick();
    check("t5_r0_done", 32'(r0_done), 32'd1);
    check("t5_r0_rdata", r0_rdata, 32'h600DCAFE);
    check("t5_r1_rdata_hold", r1_rdata, 32'h0BADF00D);

    // Latency-3 instance: three strobe cycles, done at T+5
    mem_read_data = 32'h55AA55AA;
    p0_req = 1; p0_we = 0; p0_addr = 32'h4000;
    tick();
    check("t6_gnt", 32'(p0_gnt), 32'd1);
    check("t6_rd_c1", 32'(p_memread), 32'd1);
    p0_req = 0;
    tick();
    check("t6_rd_c2", 32'(p_memread), 32'd1);
    tick();
    check("t6_rd_c3", 32'(p_memread), 32'd1);
    check("t6_done_early", 32'(p0_done), 32'd0);
    tick();
    check("t6_rd_low", 32'(p_memread), 32'd0);
    check("t6_done_t4", 32'(p0_done), 32'd0);
    tick();
    check("t6_done", 32'(p0_done), 32'd1);
    check("t6_rdata", p0_rdata, 32'h55AA55AA);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer in front of the data memory. It shares the single data-memory port between requester 0 (core load/store unit) and requester 1 (debug/DMA loader). It owns the memory's two-phase read/write protocol: it holds strobes for exactly the access latency, then drops them. It returns read data and a completion pulse to whichever requester was granted.

## Interface
- `ACCESS_LAT`, default 2: cycles the memory strobes are held per access; legal range ≥1.
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `r0_req` in 1: requester 0 access request; held until `r0_gnt`.
- `r0_we` in 1: 1 = write, 0 = read.
- `r0_addr` in 32: byte address, passed through undecoded (LED register at 0x2000 included).
- `r0_wdata` in 32: store data.
- `r0_sign_mask` in 4: size/sign code, forwarded unchanged.
- `r0_gnt` out 1: one-cycle pulse; request accepted.
- `r0_done` out 1: one-cycle pulse; access complete.
- `r0_rdata` out 32: load result; valid while `r0_done`=1 and held until next read completion for r0.
- `r1_req`, `r1_we`, `r1_addr`, `r1_wdata`, `r1_sign_mask`, `r1_gnt`, `r1_done`, `r1_rdata`: identical set for requester 1.
- `mem_addr` out 32, `mem_write_data` out 32, `mem_sign_mask` out 4: latched command of the granted requester.
- `mem_memread` out 1, `mem_memwrite` out 1: memory strobes.
- `mem_read_data` in 32: memory read result (registered inside the memory).

## Operation
- FSM states: IDLE, ACCESS, DONE. Counter `cnt` counts 0..ACCESS_LAT-1 in ACCESS.
- IDLE: if any `req`=1, pick a winner and latch its addr/wdata/sign_mask/we and owner id. Then go to ACCESS with `cnt`=0. If no request, stay in IDLE.
- Arbitration with both requests high:
  - Round-robin (see Configuration): the winner is the requester not granted last.
  - Pointer resets to "r1 last", so r0 wins the first tie.
- ACCESS:
  - `mem_memread`=~we or `mem_memwrite`=we held high every cycle.
  - The owner's `gnt` is high in the first ACCESS cycle only.
  - After ACCESS_LAT cycles, go to DONE.
- DONE:
  - Both strobes low; `mem_read_data` is valid.
  - At the end of DONE: for a read, owner `rdata` ← `mem_read_data`. For a write, `rdata` is unchanged.
  - Owner `done` is registered high for the next cycle; go to IDLE.
- The low-strobe DONE cycle is mandatory: it returns the memory's internal phase to ready.
- Requests arriving during ACCESS/DONE, including from the owner, are ignored until IDLE. A `req` dropped before `gnt` produces no access.
- `mem_*` command outputs hold the last latched values when idle; only the strobes gate activity.

## Timing
- Read or write, request sampled in IDLE at cycle T:
  - `gnt` at T+1.
  - Strobes T+1..T+ACCESS_LAT.
  - DONE at T+ACCESS_LAT+1.
  - `done`/`rdata` at T+ACCESS_LAT+2 (T+4 at default).
- `done` coincides with IDLE, so a new request is accepted in that same cycle. Peak throughput is one access per ACCESS_LAT+2 cycles.
- Reset values:
  - All `gnt`, `done`, strobes = 0.
  - `rdata` = 0, `mem_addr`/`mem_write_data` = 0, `mem_sign_mask` = 0.
  - State IDLE, RR pointer = r1.
- Reset mid-access:
  - Strobes low on the next cycle; no `gnt`/`done` is issued for the aborted access.
  - A write may or may not have committed.
  - One low-strobe cycle (the reset cycle) re-arms the memory, so any reset ≥1 cycle is sufficient.
- `rst` has priority over all other inputs in the same cycle.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin arbitration as above; a continuously requesting requester waits at most one access.
- Undefined: fixed priority, r0 always wins ties, and the RR pointer is not implemented. r1 may starve while r0 requests back-to-back.
- All latencies are identical in both builds.

## Test plan
- r0 read at 0x1004, mem returns 0xDEADBEEF → `r0_gnt` at T+1, `mem_memread` high for 2 cycles, `r0_done`=1 with `r0_rdata`=0xDEADBEEF at T+4; r1 outputs stay 0.
- r1 write 0x000000A5 to 0x2000 with byte sign_mask → `mem_memwrite` high for exactly 2 cycles with `mem_addr`=0x2000; `r1_done` at T+4; `r1_rdata` unchanged.
- Both requesting continuously, RR build → grants alternate r0, r1, r0, r1 every 4 cycles. Fixed build → r0 only, `r1_gnt` never asserted.
- Reset asserted in the first ACCESS cycle → strobes 0 next cycle, no `done`. A new r0 read after reset completes with correct data at T+4.
- `r0_req` pulsed one cycle while r1 owns the access → no r0 grant. Then r0 held through r1's `done` cycle → `r0_gnt` one cycle after r1's `done`.
- ACCESS_LAT=3 → strobes held 3 cycles, `done` at T+5.
